// File: rtl/regmem_scoreboard.sv
// Register file with same-cycle write bypass and a per-register pending scoreboard
// that stalls readers of registers still awaiting a long-latency producer.
module regmem_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         write_enable,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         stall,
    output logic [ADDR_W:0]              pending_cnt,
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              wr_en_c;
    logic              iss_en_c;

    assign wr_en_c  = write_enable && (reg_addr != '0);
    assign iss_en_c = issue_valid && (issue_addr != '0);

    // Write clears first so a same-edge issue to the same register keeps it pending.
    always_comb begin
        pending_next = pending;
        if (wr_en_c) begin
            pending_next[reg_addr] = 1'b0;
        end
        if (iss_en_c) begin
            pending_next[issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            cnt_next = cnt_next + CNT_W'(pending_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_en_c) begin
                regs[reg_addr] <= write_data;
            end
            pending     <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

    // Combinational read ports with writeback bypass.
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        logic              hit_c;

        assign addr_c = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit_c  = wr_en_c && (reg_addr == addr_c);

        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = regs[addr_c];
            if (addr_c == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (hit_c) begin
                rd_data[i*DATA_W +: DATA_W] = write_data;
            end
        end

        assign rd_busy[i] = pending[addr_c] && !hit_c && (addr_c != '0);
    end

    assign stall = |rd_busy;

    always_comb begin
        dbg_data = regs[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end else if (wr_en_c && (reg_addr == dbg_addr)) begin
            dbg_data = write_data;
        end
    end

endmodule

// File: tb/tb_regmem_scoreboard.sv
// Bench for regmem_scoreboard: directed scenarios with literal expectations, random
// traffic against a behavioural model, and a 3-port / 4-bit-address instance.
module tb_regmem_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        write_enable;
    logic [4:0]  reg_addr;
    logic [31:0] write_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        stall;
    logic [5:0]  pending_cnt;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    regmem_scoreboard dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .write_enable(write_enable), .reg_addr(reg_addr),
        .write_data(write_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .stall(stall), .pending_cnt(pending_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Small instance
    logic        b_reset;
    logic [11:0] b_rd_addr;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_we;
    logic [3:0]  b_reg_addr;
    logic [15:0] b_wdata;
    logic        b_iv;
    logic [3:0]  b_ia;
    logic        b_stall;
    logic [4:0]  b_cnt;
    logic [3:0]  b_dbg_addr;
    logic [15:0] b_dbg_data;

    regmem_scoreboard #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(3)) dut_b (
        .clk(clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .write_enable(b_we), .reg_addr(b_reg_addr),
        .write_data(b_wdata), .issue_valid(b_iv), .issue_addr(b_ia),
        .stall(b_stall), .pending_cnt(b_cnt), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register values and the set of pending registers
    logic [31:0] m_regs [32];
    bit   [31:0] m_pend;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) m_regs[k] = '0;
            m_pend = '0;
        end else begin
            if (write_enable && reg_addr != 0) begin
                m_regs[reg_addr] = write_data;
                m_pend[reg_addr] = 1'b0;
            end
            if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (write_enable && reg_addr == a) return write_data;
        return m_regs[a];
    endfunction

    // Compare process: every cycle, mid-period
    always @(negedge clk) begin : cmp
        logic [63:0] ed;
        logic [1:0]  eb;
        logic [4:0]  a;
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                ed[p*32 +: 32] = m_read(a);
                eb[p] = m_pend[a] && !(write_enable && reg_addr == a);
            end
            chk("m_rd_data", rd_data, ed);
            chk("m_rd_busy", 64'(rd_busy), 64'(eb));
            chk("m_stall", 64'(stall), 64'(|eb));
            chk("m_pending_cnt", 64'(pending_cnt), 64'($countones(m_pend)));
            chk("m_dbg_data", 64'(dbg_data), 64'(m_read(dbg_addr)));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 0; issue_valid = 0; reg_addr = '0; issue_addr = '0; write_data = '0;
    endtask

    initial begin
        reset = 1; idle(); rd_addr = '0; dbg_addr = '0;
        b_reset = 1; b_rd_addr = '0; b_we = 0; b_reg_addr = '0; b_wdata = '0;
        b_iv = 0; b_ia = '0; b_dbg_addr = '0;
        cycle(); cycle();
        reset = 0; b_reset = 0; chk_en = 1;
        rd_addr = {5'd7, 5'd3};
        @(negedge clk);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_cnt", 64'(pending_cnt), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);

        // Consecutive writes, then read on both ports
        cycle(); write_enable = 1; reg_addr = 5'd1; write_data = 32'hAAAABBBB;
        cycle(); reg_addr = 5'd2; write_data = 32'h12345678;
        cycle(); idle(); rd_addr = {5'd2, 5'd1};
        @(negedge clk);
        chk("two_writes", rd_data, {32'h12345678, 32'hAAAABBBB});

        // Same-cycle bypass and r0 immunity
        cycle(); write_enable = 1; reg_addr = 5'd3; write_data = 32'hCAFEBABE; rd_addr = {5'd0, 5'd3};
        @(negedge clk);
        chk("bypass_p0", 64'(rd_data[31:0]), 64'hCAFEBABE);
        cycle(); reg_addr = 5'd0; write_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        @(negedge clk);
        chk("r0_bypass", rd_data, 64'h0);
        cycle(); idle();
        @(negedge clk);
        chk("r0_after", rd_data, 64'h0);
        chk("r0_dbg", 64'(dbg_data), 64'h0);

        // Issue then writeback releases stall
        cycle(); issue_valid = 1; issue_addr = 5'd5;
        cycle(); idle(); rd_addr = {5'd5, 5'd0};
        @(negedge clk);
        chk("busy_r5", 64'(rd_busy), 64'b10);
        chk("stall_r5", 64'(stall), 64'd1);
        chk("cnt_r5", 64'(pending_cnt), 64'd1);
        cycle(); write_enable = 1; reg_addr = 5'd5; write_data = 32'h00000042;
        @(negedge clk);
        chk("busy_release", 64'(rd_busy), 64'b00);
        chk("stall_release", 64'(stall), 64'd0);
        cycle(); idle();
        @(negedge clk);
        chk("cnt_release", 64'(pending_cnt), 64'd0);
        chk("r5_data", 64'(rd_data[63:32]), 64'h42);

        // Simultaneous issue and write to r7, then re-issue
        cycle(); issue_valid = 1; issue_addr = 5'd7; write_enable = 1; reg_addr = 5'd7; write_data = 32'h11111111;
        cycle(); idle(); rd_addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("r7_data", rd_data, {32'h11111111, 32'h11111111});
        chk("r7_busy", 64'(rd_busy), 64'b11);
        chk("r7_cnt", 64'(pending_cnt), 64'd1);
        cycle(); issue_valid = 1; issue_addr = 5'd7;
        cycle(); idle();
        @(negedge clk);
        chk("r7_reissue_cnt", 64'(pending_cnt), 64'd1);

        // Three pending (r7 retired alongside), then reset beats a write
        cycle(); issue_valid = 1; issue_addr = 5'd4; write_enable = 1; reg_addr = 5'd7; write_data = 32'h0;
        cycle(); idle(); issue_valid = 1; issue_addr = 5'd6;
        cycle(); issue_addr = 5'd9;
        cycle(); idle();
        @(negedge clk);
        chk("cnt_three", 64'(pending_cnt), 64'd3);
        cycle(); reset = 1; write_enable = 1; reg_addr = 5'd4; write_data = 32'h1234; rd_addr = {5'd4, 5'd1};
        cycle(); reset = 0; idle();
        @(negedge clk);
        chk("rst_rd", rd_data, 64'h0);
        chk("rst_cnt", 64'(pending_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // Random traffic, biased toward a few registers to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            cycle();
            reset        = ($urandom_range(0, 99) == 0);
            write_enable = $urandom_range(0, 1);
            reg_addr     = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
            write_data   = $urandom;
            issue_valid  = ($urandom_range(0, 2) == 0);
            issue_addr   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
            rd_addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            dbg_addr     = 5'($urandom_range(0, 7));
        end
        cycle(); reset = 0; idle();

        // Three-port narrow instance
        b_we = 1; b_reg_addr = 4'd15; b_wdata = 16'hBEEF;
        cycle(); b_we = 0; b_rd_addr = {4'd15, 4'd15, 4'd15};
        @(negedge clk);
        chk("b_three_ports", 64'(b_rd_data), {16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF});
        for (int r = 1; r < 16; r++) begin
            cycle(); b_iv = 1; b_ia = 4'(r);
        end
        cycle(); b_iv = 0;
        @(negedge clk);
        chk("b_cnt_15", 64'(b_cnt), 64'd15);
        chk("b_busy_all", 64'(b_rd_busy), 64'b111);

        cycle();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regmem_scoreboard.md
REGMEM_SCOREBOARD -- requirements
Module: regmem_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width; NREGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter RD_PORTS, default 2, giving the number of independent read ports (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port rd_addr, input, RD_PORTS*ADDR_W bits: packed read addresses, port i in bits [i*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have port rd_data, output, RD_PORTS*DATA_W bits: packed read data, port i in bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port rd_busy, output, RD_PORTS bits: bit i set means the register on port i awaits a pending write.
REQ-009 The block SHALL have port write_enable, input, 1 bit: writeback strobe.
REQ-010 The block SHALL have port reg_addr, input, ADDR_W bits: writeback destination.
REQ-011 The block SHALL have port write_data, input, DATA_W bits: writeback value.
REQ-012 The block SHALL have port issue_valid, input, 1 bit: a long-latency producer (load) targeting issue_addr is issued.
REQ-013 The block SHALL have port issue_addr, input, ADDR_W bits: destination register of the issued producer.
REQ-014 The block SHALL have port stall, output, 1 bit: OR of all rd_busy bits.
REQ-015 The block SHALL have port pending_cnt, output, ADDR_W+1 bits: number of registers currently marked pending.
REQ-016 The block SHALL have port dbg_addr, input, ADDR_W bits, and port dbg_data, output, DATA_W bits: a side-effect-free debug read.

Function
REQ-017 Register 0 SHALL always read 0; writes and issues to address 0 SHALL be ignored.
REQ-018 With write_enable=1 and reg_addr!=0, the register SHALL take write_data at the rising clk edge.
REQ-019 Reads on every port and on dbg SHALL be combinational from the address.
REQ-020 Same-cycle write bypass: if write_enable=1, reg_addr!=0 and reg_addr equals a read address, that port (and dbg) SHALL return write_data in the same cycle.
REQ-021 Scoreboard: one pending bit per register; issue_valid=1 with issue_addr!=0 SHALL set the bit at the clk edge.
REQ-022 write_enable=1 with reg_addr!=0 SHALL clear the pending bit of reg_addr at the clk edge.
REQ-023 Simultaneous issue and write to the same address SHALL leave the bit set (new producer wins); to different addresses both SHALL take effect.
REQ-024 Issuing to an already-pending register SHALL keep it set, and pending_cnt SHALL be unchanged.
REQ-025 Writing to a non-pending register SHALL update data only; pending_cnt SHALL not underflow.
REQ-026 rd_busy[i] SHALL equal pending[rd_addr_i] AND NOT (write_enable AND reg_addr==rd_addr_i), so a same-cycle writeback releases the stall; address 0 is never busy.
REQ-027 pending_cnt SHALL equal the population count of the registered pending vector and SHALL reflect an edge's update in the following cycle.

Reset
REQ-028 With reset=1 at a clk edge, all registers SHALL become 0 and all pending bits SHALL clear; rd_data reads 0, rd_busy=0, stall=0, pending_cnt=0 afterwards.
REQ-029 Reset SHALL take priority over write_enable and issue_valid in the same cycle, including mid-operation with pending bits set.

Verification
REQ-030 Write r1=AAAABBBB, r2=12345678 on consecutive edges, then rd_addr={2,1} -> rd_data port0=AAAABBBB, port1=12345678.
REQ-031 Drive write_enable=1, reg_addr=3, write_data=CAFEBABE with rd_addr port0=3 before the edge -> port0 reads CAFEBABE in the same cycle; a write to r0 with DEADBEEF -> r0 still reads 0.
REQ-032 issue r5, next cycle rd_addr port1=5 -> rd_busy=2'b10, stall=1, pending_cnt=1; then write r5=00000042 -> rd_busy=0 in that cycle, pending_cnt=0 after the edge, port1 reads 00000042.
REQ-033 Same cycle: issue r7 and write r7=11111111 -> after the edge r7=11111111, pending[7]=1, pending_cnt=1; issue r7 again -> pending_cnt stays 1.
REQ-034 Issue r4, r6, r9 (pending_cnt=3), then assert reset together with write r4 -> after the edge all reads 0, pending_cnt=0, stall=0.
REQ-035 Instantiate RD_PORTS=3, ADDR_W=4, DATA_W=16: write r15=BEEF, read it on all three ports -> each returns BEEF; pending_cnt width 5 and reaches 15 after issuing r1..r15.
